// File: rtl/lcd_rx_pkg.sv
// Shared types, constants and helpers for the receive-side model of the 4-bit
// character-LCD bus.
package lcd_rx_pkg;

  typedef enum logic [1:0] {
    ST_INIT8 = 2'd0,
    ST_HI    = 2'd1,
    ST_LO    = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISPLAY,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } cmd_op_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [6:0] ADDR_L1_END   = 7'h27;
  localparam logic [6:0] ADDR_L2_BEGIN = 7'h40;
  localparam logic [6:0] ADDR_L2_END   = 7'h67;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  // Commands are identified by their highest set bit.
  function automatic cmd_op_t decode_cmd(input logic [7:0] b);
    cmd_op_t op;
    if      (|(b & CMD_DDRAM))   op = OP_DDRAM;
    else if (|(b & CMD_CGRAM))   op = OP_CGRAM;
    else if (|(b & CMD_FUNC))    op = OP_FUNC;
    else if (|(b & CMD_SHIFT))   op = OP_SHIFT;
    else if (|(b & CMD_DISPLAY)) op = OP_DISPLAY;
    else if (|(b & CMD_ENTRY))   op = OP_ENTRY;
    else if (|(b & CMD_HOME))    op = OP_HOME;
    else if (|(b & CMD_CLEAR))   op = OP_CLEAR;
    else                         op = OP_NONE;
    return op;
  endfunction

  // Two 40-slot lines: 0x00-0x27 and 0x40-0x67. Out-of-range addresses snap
  // to the start of the following line whatever the direction.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] n;
    if (a > ADDR_L1_END && a < ADDR_L2_BEGIN) n = ADDR_L2_BEGIN;
    else if (a > ADDR_L2_END)                 n = 7'h00;
    else if (up) begin
      if (a == ADDR_L1_END)      n = ADDR_L2_BEGIN;
      else if (a == ADDR_L2_END) n = 7'h00;
      else                       n = a + 7'd1;
    end else begin
      if (a == ADDR_L2_BEGIN)    n = ADDR_L1_END;
      else if (a == 7'h00)       n = ADDR_L2_END;
      else                       n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_rx_if.sv
// LCD pin bundle between the writer (master) and this receiver (slave).
interface lcd_rx_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_D;

  // A nibble is taken on the falling edge of LCD_E; RS/RW/D must be stable
  // around that edge. There is no back-pressure: the receiver never stalls.
  modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_D);
  modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_D);
endinterface

// File: rtl/lcd_rx_sync.sv
// Multi-stage synchronizer for the LCD pins plus falling-edge detect on E.
module lcd_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [3:0] i_d,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [3:0] d
);

  logic [SYNC_STAGES-1:0][6:0] r_sync;
  logic                        r_e_prev;
  logic [6:0]                  w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_e_prev <= 1'b0;
    end else begin
      r_sync[0] <= {i_e, i_rs, i_rw, i_d};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_e_prev <= w_last[6];
    end
  end

  // RS/RW/D come from the same synchronized sample that shows E low.
  assign strobe = r_e_prev & ~w_last[6];
  assign rs     = w_last[5];
  assign rw     = w_last[4];
  assign d      = w_last[3:0];

endmodule

// File: rtl/lcd_rx.sv
// Decodes 4-bit LCD bus strobes into commands/data and mirrors the two
// visible 16-character lines.
module lcd_rx
  import lcd_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  lcd_rx_if.slave       lcd,
  output logic [127:0]  row_A,
  output logic [127:0]  row_B,
  output logic          display_on,
  output logic          cmd_valid,
  output logic          data_valid,
  output logic [7:0]    rx_byte,
  output logic          busy,
  output logic          err,
  output state_t        o_dbg_state,
  output logic [6:0]    o_dbg_addr
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  logic          w_strobe, w_rs, w_rw;
  logic [3:0]    w_d;
  logic          w_accept;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_hi_nib;
  logic          r_hi_rs;
  logic [6:0]    r_addr;
  logic          r_inc;
  logic          r_cg;
  logic [CW-1:0] r_busy_cnt;
  logic          w_busy;
  logic [127:0]  r_row_a, r_row_b;
  logic          r_display, r_cmd_valid, r_data_valid, r_err;
  logic [7:0]    r_rx_byte;

  logic          w_exec, w_exec_rs, w_load_hi, w_err_set;
  logic [7:0]    w_exec_byte;
  cmd_op_t       w_op;

  lcd_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_e    (lcd.LCD_E),
    .i_rs   (lcd.LCD_RS),
    .i_rw   (lcd.LCD_RW),
    .i_d    (lcd.LCD_D),
    .strobe (w_strobe),
    .rs     (w_rs),
    .rw     (w_rw),
    .d      (w_d)
  );

  // Read strobes are invisible to the decoder, including the nibble phase.
  assign w_accept = w_strobe & ~w_rw;
  assign w_busy   = (r_busy_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT8;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_accept) begin
      case (r_state)
        ST_INIT8: if (!w_rs && w_d == 4'h2) w_state_nx = ST_HI;
        ST_HI:    w_state_nx = ST_LO;
        ST_LO:    w_state_nx = ST_HI;
        default:  w_state_nx = ST_INIT8;
      endcase
    end
  end

  always_comb begin
    w_exec      = 1'b0;
    w_exec_rs   = 1'b0;
    w_exec_byte = 8'h00;
    w_load_hi   = 1'b0;
    w_err_set   = 1'b0;
    if (w_accept) begin
      w_err_set = w_busy;
      case (r_state)
        ST_INIT8: begin
          if (!w_rs && w_d == 4'h2) begin
            w_exec      = 1'b1;
            w_exec_byte = {w_d, 4'h0};
          end else if (w_rs || w_d != 4'h3) begin
            w_err_set = 1'b1;
          end
        end
        ST_HI: w_load_hi = 1'b1;
        ST_LO: begin
          w_exec      = 1'b1;
          w_exec_rs   = r_hi_rs;
          w_exec_byte = {r_hi_nib, w_d};
          if (w_rs != r_hi_rs) w_err_set = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_op = decode_cmd(w_exec_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_nib     <= 4'h0;
      r_hi_rs      <= 1'b0;
      r_addr       <= 7'h00;
      r_inc        <= 1'b1;
      r_cg         <= 1'b0;
      r_busy_cnt   <= '0;
      r_display    <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_rx_byte    <= 8'h00;
      r_err        <= 1'b0;
    end else begin
      r_cmd_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      if (w_busy)    r_busy_cnt <= r_busy_cnt - 1'b1;
      if (w_err_set) r_err      <= 1'b1;
      if (w_load_hi) begin
        r_hi_nib <= w_d;
        r_hi_rs  <= w_rs;
      end
      if (w_exec) begin
        r_rx_byte <= w_exec_byte;
        if (!w_exec_rs) begin
          r_cmd_valid <= 1'b1;
          case (w_op)
            OP_CLEAR: begin
              r_addr     <= 7'h00;
              r_inc      <= 1'b1;
              r_busy_cnt <= CW'(CLEAR_CYCLES);
            end
            OP_HOME:    r_addr    <= 7'h00;
            OP_ENTRY:   r_inc     <= w_exec_byte[1];
            OP_DISPLAY: r_display <= w_exec_byte[2];
            OP_SHIFT:   if (!w_exec_byte[3]) r_addr <= step_addr(r_addr, w_exec_byte[2]);
            OP_CGRAM:   r_cg      <= 1'b1;
            OP_DDRAM: begin
              r_addr <= w_exec_byte[6:0];
              r_cg   <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          r_data_valid <= 1'b1;
          // CGRAM contents are not mirrored, so CG-mode writes are dropped.
          if (!r_cg) r_addr <= step_addr(r_addr, r_inc);
        end
      end
    end
  end

  // Address 0x00/0x40 is the leftmost character, held in the top byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_a <= {16{CHAR_SPACE}};
      r_row_b <= {16{CHAR_SPACE}};
    end else if (w_exec && !w_exec_rs && w_op == OP_CLEAR) begin
      r_row_a <= {16{CHAR_SPACE}};
      r_row_b <= {16{CHAR_SPACE}};
    end else if (w_exec && w_exec_rs && !r_cg) begin
      for (int i = 0; i < 16; i++) begin
        if (r_addr == 7'(i))                   r_row_a[(15-i)*8 +: 8] <= w_exec_byte;
        if (r_addr == 7'(i) + ADDR_L2_BEGIN)   r_row_b[(15-i)*8 +: 8] <= w_exec_byte;
      end
    end
  end

  assign row_A       = r_row_a;
  assign row_B       = r_row_b;
  assign display_on  = r_display;
  assign cmd_valid   = r_cmd_valid;
  assign data_valid  = r_data_valid;
  assign rx_byte     = r_rx_byte;
  assign busy        = w_busy;
  assign err         = r_err;
  assign o_dbg_state = r_state;
  assign o_dbg_addr  = r_addr;

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: drives nibble strobes on the LCD pins and checks
// executed bytes against an expected queue plus row/flag state after each step.
module tb_lcd_rx;
  import lcd_rx_pkg::*;

  logic         clk;
  logic         rst;
  lcd_rx_if     lcd();
  logic [127:0] row_A, row_B;
  logic         display_on, cmd_valid, data_valid, busy, err;
  logic [7:0]   rx_byte;
  state_t       dbg_state;
  logic [6:0]   dbg_addr;

  int total = 0;
  int bad   = 0;

  // {cmd_valid, data_valid, rx_byte} expected for each executed byte
  logic [9:0] exp_q[$];

  localparam logic [127:0] BLANK = {16{8'h20}};

  lcd_rx #(.SYNC_STAGES(2), .CLEAR_CYCLES(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd         (lcd.slave),
    .row_A       (row_A),
    .row_B       (row_B),
    .display_on  (display_on),
    .cmd_valid   (cmd_valid),
    .data_valid  (data_valid),
    .rx_byte     (rx_byte),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (dbg_state),
    .o_dbg_addr  (dbg_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
    @(posedge clk); #1;
    lcd.LCD_RS = rs;
    lcd.LCD_RW = rw;
    lcd.LCD_D  = d;
    lcd.LCD_E  = 1'b1;
    repeat (2) @(posedge clk);
    #1 lcd.LCD_E = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send(input logic rs, input logic [7:0] b);
    exp_q.push_back({~rs, rs, b});
    nib(rs, 1'b0, b[7:4]);
    nib(rs, 1'b0, b[3:0]);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  // scoreboard: pop one expectation per executed-byte pulse
  always @(negedge clk) begin
    if (!rst && (cmd_valid || data_valid)) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {cmd_valid, data_valid, rx_byte}, 10'h0);
      else                   chk("rx_byte", {cmd_valid, data_valid, rx_byte}, exp_q.pop_front());
    end
  end

  initial begin
    lcd.LCD_E  = 1'b0;
    lcd.LCD_RS = 1'b0;
    lcd.LCD_RW = 1'b0;
    lcd.LCD_D  = 4'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row_a", row_A, BLANK);
    chk("rst_row_b", row_B, BLANK);
    chk("rst_flags", {display_on, cmd_valid, data_valid, busy, err}, 5'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_state", dbg_state, ST_INIT8);
    chk("rst_addr", dbg_addr, 7'h00);
    rst = 1'b0;

    // init sequence and first write
    nib(1'b0, 1'b0, 4'h3);
    nib(1'b0, 1'b0, 4'h3);
    nib(1'b0, 1'b0, 4'h3);
    exp_q.push_back({1'b1, 1'b0, 8'h20});
    nib(1'b0, 1'b0, 4'h2);
    settle();
    chk("init_state_hi", dbg_state, ST_HI);
    send(1'b0, 8'h28);
    send(1'b0, 8'h0C);
    send(1'b0, 8'h01);
    settle();
    chk("clear_busy_on", busy, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("clear_busy_off", busy, 1'b0);
    send(1'b1, 8'h41);
    settle();
    chk("display_on", display_on, 1'b1);
    chk("first_row_a", row_A, {8'h41, {15{8'h20}}});
    chk("first_row_b", row_B, BLANK);
    chk("first_err", err, 1'b0);

    // line 2 write
    send(1'b0, 8'hC0);
    send(1'b1, 8'h48);
    send(1'b1, 8'h69);
    settle();
    chk("l2_chars", row_B[127:112], 16'h4869);
    chk("l2_row_a_kept", row_A, {8'h41, {15{8'h20}}});
    chk("l2_addr", dbg_addr, 7'h42);

    // wrap-around 0x27 -> 0x40
    send(1'b0, 8'hA7);
    send(1'b1, 8'h78);
    settle();
    chk("wrap_addr", dbg_addr, 7'h40);
    chk("wrap_hidden_a", row_A, {8'h41, {15{8'h20}}});
    send(1'b1, 8'h79);
    settle();
    chk("wrap_row_b", row_B, {8'h79, 8'h69, {14{8'h20}}});

    // decrement mode, 0x00 -> 0x67
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    send(1'b1, 8'h7A);
    settle();
    chk("dec_row_a", row_A, {8'h7A, {15{8'h20}}});
    chk("dec_addr", dbg_addr, 7'h67);
    send(1'b1, 8'h71);
    settle();
    chk("dec_hidden_a", row_A, {8'h7A, {15{8'h20}}});
    chk("dec_hidden_b", row_B, {8'h79, 8'h69, {14{8'h20}}});
    chk("dec_addr2", dbg_addr, 7'h66);

    // read strobe between nibbles is ignored
    send(1'b0, 8'h06);
    send(1'b0, 8'h80);
    exp_q.push_back({1'b0, 1'b1, 8'h6B});
    nib(1'b1, 1'b0, 4'h6);
    nib(1'b1, 1'b1, 4'hF);
    nib(1'b1, 1'b0, 4'hB);
    settle();
    chk("rw_row_a", row_A, {8'h6B, {15{8'h20}}});
    chk("rw_err", err, 1'b0);

    // strobe during busy still executes but flags an error
    send(1'b0, 8'h01);
    send(1'b1, 8'h61);
    settle();
    chk("busy_err", err, 1'b1);
    chk("busy_row_a", row_A, {8'h61, {15{8'h20}}});
    chk("busy_row_b", row_B, BLANK);

    // reset after a high nibble
    repeat (40) @(posedge clk);
    nib(1'b0, 1'b0, 4'h8);
    settle();
    chk("mid_state_lo", dbg_state, ST_LO);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", dbg_state, ST_INIT8);
    chk("mid_rst_row_a", row_A, BLANK);
    chk("mid_rst_err", err, 1'b0);
    rst = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 8'h20});
    nib(1'b0, 1'b0, 4'h2);
    settle();
    chk("mid_func_set", dbg_state, ST_HI);
    chk("mid_row_b", row_B, BLANK);

    // bad nibble during init
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nib(1'b0, 1'b0, 4'h7);
    settle();
    chk("init_bad_err", err, 1'b1);
    chk("init_bad_state", dbg_state, ST_INIT8);

    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_rx.md
# lcd_rx

Receive-side model of the 4-bit character-LCD bus driven by the team's `lcd` writer. It decodes `LCD_E`/`LCD_RS`/`LCD_RW`/`LCD_D` strobes into commands and data and keeps a mirror of the two visible 16-character lines. Its outputs use the same `row_A`/`row_B` packing the writer consumes. It sits in simulation benches and on-chip loopback checks, directly on the writer's LCD pins.

## Interface
- `SYNC_STAGES`, default 2: flops in the input synchronizer. Must be 2 or more.
- `CLEAR_CYCLES`, default 32: number of cycles `busy` stays high after a Clear command.
- `clk` input, 1 bit: the only clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `LCD_E` input, 1 bit: enable strobe. A nibble is latched on its falling edge.
- `LCD_RS` input, 1 bit: 0 selects a command, 1 selects data.
- `LCD_RW` input, 1 bit: 1 marks a read strobe.
- `LCD_D` input, 4 bits: data nibble.
- `row_A` output, 128 bits: line 1. Leftmost character is in `[127:120]`.
- `row_B` output, 128 bits: line 2, same packing.
- `display_on` output, 1 bit: the D bit from the last Display Control command.
- `cmd_valid` output, 1 bit: one-cycle pulse when a command byte executes.
- `data_valid` output, 1 bit: one-cycle pulse when a data byte executes.
- `rx_byte` output, 8 bits: the last executed byte. Held between pulses.
- `busy` output, 1 bit: high while the Clear busy period is running.
- `err` output, 1 bit: sticky error flag. Cleared only by `rst`.

## Operation
- **Input stage:**
  - All four inputs pass through `SYNC_STAGES` flops.
  - A strobe is a cycle where synchronized E was 1 in the previous cycle and is 0 now.
  - RS, RW and D are taken from the same synchronized cycle as the falling edge.
- **Read strobes:** a strobe with RW=1 is ignored entirely and does not change the nibble phase.
- **States:**
  - **INIT8:** every strobe is an 8-bit-mode command, using D as the upper nibble and 0 as the lower nibble.
    - Strobe with RS=0 and D=0x3 stays in INIT8 and is not reported.
    - Strobe with RS=0 and D=0x2 goes to HI and pulses `cmd_valid` with `rx_byte`=0x20.
    - Any other strobe sets `err` and stays in INIT8.
  - **HI:** the strobe is stored as the high nibble along with its RS value. Go to LO.
  - **LO:** combine the stored high nibble with the current D.
    - If RS differs from the stored RS, set `err`; the byte still executes using the RS captured in HI.
    - Execute the byte and go back to HI.
- **Commands (RS=0):** decoded by highest set bit.
  - 0x01 Clear: both rows become 0x20 (space), address 0, increment mode on, `busy` starts.
  - 0x02–0x03 Home: address 0.
  - 0x04–0x07 Entry Mode: `inc` takes bit 1. The shift bit is ignored.
  - 0x08–0x0F Display Control: `display_on` takes bit 2.
  - 0x10–0x1F Cursor Shift: if bit 3=0, move the address by +1 when bit 2=1, else by −1.
  - 0x20–0x3F Function Set: no effect.
  - 0x40–0x7F CGRAM address: enter CG mode. Data writes in CG mode are discarded.
  - 0x80–0xFF DDRAM address: address becomes the low 7 bits; leave CG mode.
- **Data (RS=1):**
  - Address 0x00–0x0F writes character `15-addr` of `row_A`.
  - Address 0x40–0x4F writes character `15-(addr-0x40)` of `row_B`.
  - Any other address is accepted but not displayed.
  - The address then steps by `inc`.
- **Address arithmetic:** 7-bit address with wrap-around.
  - Incrementing: 0x27 goes to 0x40, and 0x67 goes to 0x00.
  - Decrementing: 0x40 goes to 0x27, and 0x00 goes to 0x67.
  - A DDRAM set to an unused value (0x28–0x3F or 0x68–0x7F) is stored as given. The next step from 0x28–0x3F goes to 0x40 and from 0x68–0x7F goes to 0x00.
- **Strobe while `busy`:** the byte executes normally and `err` is set. A new Clear restarts the busy counter.

## Timing
- **Reset values:**
  - `row_A` and `row_B` are all 0x20.
  - `display_on`, `cmd_valid`, `data_valid`, `busy` and `err` are 0; `rx_byte` is 0x00.
  - State is INIT8, address 0, `inc`=1, CG mode off.
  - Reset takes effect immediately, even mid-byte; a half-received nibble is dropped.
- **Latency:**
  - The edge is detected in cycle k, which is `SYNC_STAGES`+1 cycles after E falls at the pin.
  - Rows, pulses and `rx_byte` are updated at the clock ending cycle k, so they are visible in cycle k+1.
- **Busy period:** `busy` is high for exactly `CLEAR_CYCLES` cycles, starting in the same cycle the cleared rows first appear.
- **Minimum E spacing:** one strobe is guaranteed per 2 cycles of synchronized E. Narrower pulses may be lost; no check is made for this.

## Structure
- **Package `lcd_rx_pkg`:** command decode masks, the space character 0x20, address bounds (0x27, 0x40, 0x67) and the state encoding (INIT8, HI, LO).
- **Sub-module `lcd_rx_sync`:** parameterized multi-bit synchronizer plus E falling-edge detector. Outputs `strobe`, `rs`, `rw`, `d`.
- **Top level:** the state machine, address counter, row registers and busy counter.

## Test plan
- **Init and first write:** reset; send nibbles 3,3,3,2, then 0x28, 0x0C, 0x01; wait 32 cycles; send data 'A' (0x41).
  - Expect `display_on`=1, `row_A[127:120]`=0x41, the rest of both rows 0x20, `err`=0.
- **Line 2 write:** send DDRAM 0xC0, then "Hi".
  - Expect `row_B[127:112]`=0x4869 and `row_A` unchanged.
- **Wrap-around:** send DDRAM 0xA7, then data 'x', then 'y'.
  - Expect the address to go 0x27→0x40, so 'y' lands in `row_B[127:120]`.
- **Decrement mode:** send Entry Mode 0x04, DDRAM 0x80, data 'z'.
  - Expect `row_A[127:120]`='z' and the address to become 0x67; a second data write is not displayed.
- **Error cases:**
  - A strobe during `busy` sets `err`.
  - An RW=1 strobe between nibbles leaves the decoded byte intact and `err` unchanged.
- **Reset mid-byte:** assert `rst` after a high nibble.
  - Expect state INIT8, both rows 0x20, and the next 0x2 nibble accepted as Function Set.
